// File: rtl/lsu_ctrl.sv
// Load/store unit: steers store lanes, extracts and extends load data, stalls the core per access.
// Latency: start in cycle 0, request in cycle 1, done pulse one cycle after mem_ready_i (or after timeout).
// Backpressure: request fields hold until mem_ready_i; stall_o holds the core. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter is 8 bits wide; the limit is taken from the low byte of the parameter.
    localparam logic [7:0] TO_LIMIT = TIMEOUT_CYCLES[7:0];

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        err_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        req_any;
    logic        req_bad;
    logic        funct3_ok;
    logic        misaligned;
    logic [3:0]  st_wstrb_d;
    logic [31:0] st_wdata_d;
    logic [31:0] ld_ext_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req_any = start_i && (is_load_i || is_store_i);
    assign cnt_d   = cnt_q + 8'd1;

    // Classify the incoming request: wrong direction encoding, bad width code, or (optionally) misaligned.
    always_comb begin
        funct3_ok = 1'b0;
        if (is_load_i) begin
            funct3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                        (funct3_i == 3'b100) || (funct3_i == 3'b101);
        end else begin
            funct3_ok = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        req_bad = (is_load_i == is_store_i) || !funct3_ok || misaligned;
    end

    // Store lane steering: byte/half data is replicated so the strobes alone pick the lanes.
    always_comb begin
        st_wstrb_d = 4'b1111;
        st_wdata_d = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_wstrb_d = 4'b0001 << addr_i[1:0];
                st_wdata_d = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                st_wstrb_d = addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_d = {2{wdata_i[15:0]}};
            end
            default: begin
                st_wstrb_d = 4'b1111;
                st_wdata_d = wdata_i;
            end
        endcase
    end

    // Load extraction and sign/zero extension from the returned word.
    always_comb begin
        ld_byte  = 8'h00;
        ld_half  = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        ld_ext_d = mem_rdata_i;
        case (off_q)
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        case (funct3_q)
            3'b000:  ld_ext_d = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext_d = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext_d = {24'h0, ld_byte};
            3'b101:  ld_ext_d = {16'h0, ld_half};
            default: ld_ext_d = mem_rdata_i;
        endcase
    end

    // Access FSM with registered memory-side outputs and completion flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'h0;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (req_any) begin
                        if (req_bad) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= 8'd0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store_i;
                            mem_addr_q  <= {addr_i[31:2], 2'b00};
                            mem_wstrb_q <= is_store_i ? st_wstrb_d : 4'b0000;
                            mem_wdata_q <= st_wdata_d;
                            funct3_q    <= funct3_i;
                            off_q       <= addr_i[1:0];
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        if (!mem_we_q) begin
                            rdata_q <= ld_ext_d;
                        end
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        err_q       <= 1'b0;
                    end else if (cnt_d == TO_LIMIT) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        rdata_q     <= 32'h0;
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        cnt_q       <= cnt_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= 8'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    // Stall is released in DONE so the core advances exactly once per instruction.
    assign stall_o     = ((state_q == S_IDLE) && req_any) || (state_q == S_REQ);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed cases, then randomized loads/stores with random memory waits.
// Expected results come from a byte-lane reference model; a responder checks requests, a monitor checks completions.
module tb_lsu_ctrl;

    localparam int T = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_req_o, mem_we_o, done_o, err_o, stall_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;
    logic [3:0]  mem_wstrb_o;

    lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .is_load_i(is_load), .is_store_i(is_store),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
        .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit err; logic [31:0] rdata; int cyc; } sb_t;
    typedef struct { logic [31:0] addr; bit we; logic [3:0] wstrb; logic [31:0] wdata; } rq_t;
    typedef struct { int wt; logic [31:0] rd; } rsp_t;

    sb_t  sb_q[$];
    rq_t  rq_q[$];
    rsp_t rsp_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_cycles = 0;
    logic [31:0] model_rdata = 32'h0;
    logic        cap_req, cap_we, cap_stall;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, wanted %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    // First byte lane touched: the access is placed on its natural boundary inside the word.
    function automatic int lane_base(input logic [31:0] a, input int sz);
        int o;
        o = int'(a[1:0]);
        return o & ~(sz - 1);
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] a, input int sz);
        logic [3:0] m;
        m = 4'((1 << sz) - 1);
        return m << lane_base(a, sz);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int sz);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int sz;
        logic [31:0] v, mask;
        sz = size_of(f3);
        v  = rd >> (8 * lane_base(a, sz));
        if (sz < 4) begin
            mask = (32'd1 << (8 * sz)) - 32'd1;
            v    = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic bit model_legal(input bit ld, input bit st, input logic [2:0] f3,
                                       input logic [31:0] a);
        if (ld == st) return 1'b0;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (size_of(f3) == 2 && a[0]) return 1'b0;
        if (size_of(f3) == 4 && a[1:0] != 2'b00) return 1'b0;
`else
        if (a[31] === 1'bx) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int wt);
        sb_t  e;
        rq_t  q;
        rsp_t r;
        int   c, sz;
        @(posedge clk); #1;
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
        c  = cyc;
        sz = size_of(f3);
        if (ld || st) begin
            if (!model_legal(ld, st, f3, a)) begin
                e.err = 1'b1; e.rdata = model_rdata; e.cyc = c + 1;
            end else begin
                q.addr  = {a[31:2], 2'b00};
                q.we    = st;
                q.wstrb = model_strb(a, sz);
                q.wdata = model_wdata(wd, sz);
                rq_q.push_back(q);
                r.wt = wt; r.rd = rd;
                rsp_q.push_back(r);
                if (wt < T) begin
                    if (ld) model_rdata = model_load(f3, a, rd);
                    e.err = 1'b0; e.rdata = model_rdata; e.cyc = c + 2 + wt;
                end else begin
                    model_rdata = 32'h0;
                    e.err = 1'b1; e.rdata = 32'h0; e.cyc = c + 1 + T;
                end
            end
            sb_q.push_back(e);
        end
        @(negedge clk);
        chk("stall_at_start", stall_o, (ld || st) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        is_load = 1'($urandom); is_store = 1'($urandom);
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        @(negedge clk);
        cap_req = mem_req_o; cap_we = mem_we_o; cap_addr = mem_addr_o;
        cap_strb = mem_wstrb_o; cap_wdata = mem_wdata_o; cap_stall = stall_o;
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            chk("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    // ---------------- memory responder / request checker ----------------
    initial begin
        bit   active;
        bit   known;
        int   n;
        rq_t  q;
        rsp_t r;
        active = 1'b0; known = 1'b0; n = 0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                req_cycles++;
                if (!active) begin
                    active = 1'b1;
                    n = 0;
                    if (rq_q.size() == 0 || rsp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_req: mem_req high with no request issued (cycle %0d)", cyc);
                        known = 1'b0;
                        r.wt = 1 << 20; r.rd = 32'h0;
                    end else begin
                        known = 1'b1;
                        q = rq_q.pop_front();
                        r = rsp_q.pop_front();
                    end
                end
                if (known) begin
                    chk("mem_addr", mem_addr_o, q.addr);
                    chk("mem_we", mem_we_o, q.we);
                    if (q.we) begin
                        chk("mem_wstrb", mem_wstrb_o, q.wstrb);
                        chk("mem_wdata", mem_wdata_o, q.wdata);
                    end
                    chk("stall_in_req", stall_o, 32'd1);
                end
                if (n == r.wt) begin
                    mem_ready = 1'b1; mem_rdata = r.rd;
                end else begin
                    mem_ready = 1'b0; mem_rdata = $urandom;
                end
                n++;
            end else begin
                active = 1'b0;
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- completion monitor ----------------
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_done: done with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("err", err_o, e.err);
                    chk("rdata", rdata_o, e.rdata);
                    chk("stall_in_done", stall_o, 32'd0);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int          rc0, k;
        bit          ld, st;
        logic [2:0]  f3;
        logic [2:0]  ld_ok [5];
        int          wt;
        ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req_o, 32'd0);
        chk("rst_mem_we", mem_we_o, 32'd0);
        chk("rst_done", done_o, 32'd0);
        chk("rst_err", err_o, 32'd0);
        chk("rst_wstrb", mem_wstrb_o, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_stall", stall_o, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        issue(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 0);
        chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
        chk("lb_mem_addr", cap_addr, 32'h0000_0100);
        issue(1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h8012_3456, 0);
        chk("lbu_rdata", rdata_o, 32'h0000_0080);

        issue(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0);
        chk("sh_we", cap_we, 32'd1);
        chk("sh_addr", cap_addr, 32'h0000_0200);
        chk("sh_wstrb", cap_strb, 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_stall_c1", cap_stall, 32'd1);
        chk("sh_rdata_kept", rdata_o, 32'h0000_0080);

        issue(1, 0, 3'b010, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 3);
        chk("lw_wait_rdata", rdata_o, 32'hDEAD_BEEF);

        rc0 = req_cycles;
        issue(1, 0, 3'b010, 32'h0000_0304, 32'h0, 32'h1111_2222, T);
        chk("timeout_req_cycles", 32'(req_cycles - rc0), 32'(T));
        chk("timeout_rdata", rdata_o, 32'h0);

        issue(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("misalign_no_req", cap_req, 32'd0);
`else
        chk("lw_unaligned_addr", cap_addr, 32'h0000_0100);
        chk("lw_unaligned_rdata", rdata_o, 32'hCAFE_F00D);
`endif
        issue(1, 1, 3'b000, 32'h0000_0010, 32'h0, 32'h0, 0);
        chk("both_set_no_req", cap_req, 32'd0);
        issue(0, 1, 3'b100, 32'h0000_0010, 32'h0, 32'h0, 0);
        issue(0, 0, 3'b000, 32'h0000_0010, 32'h0, 32'h0, 0);

        // reset in the second cycle of a waiting load
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400;
        begin
            rq_t  q;
            rsp_t r;
            q.addr = 32'h0000_0400; q.we = 1'b0; q.wstrb = 4'h0; q.wdata = 32'h0;
            rq_q.push_back(q);
            r.wt = 100; r.rd = 32'h0;
            rsp_q.push_back(r);
        end
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_rdata = 32'h0;
        @(negedge clk);
        chk("rst_req_dropped", mem_req_o, 32'd0);
        chk("rst_stall_dropped", stall_o, 32'd0);
        chk("rst_no_done", done_o, 32'd0);
        chk("rst_rdata_cleared", rdata_o, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_rst", done_o, 32'd0);
        end
        issue(0, 1, 3'b000, 32'h0000_0047, 32'h0000_00A5, 32'h0, 1);
        chk("sb_after_rst_strb", cap_strb, 32'h8);
        chk("sb_after_rst_wdata", cap_wdata, 32'hA5A5_A5A5);

        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 9);
            ld = (k <= 3) || (k == 8);
            st = (k >= 4 && k <= 8);
            if ($urandom_range(0, 9) < 8) begin
                if (ld && !st) f3 = ld_ok[$urandom_range(0, 4)];
                else           f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom);
            end
            wt = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(0, T + 1);
            issue(ld, st, f3, $urandom, $urandom, $urandom, wt);
        end

        repeat (4) @(posedge clk);
        chk("sb_left", 32'(sb_q.size()), 32'd0);
        chk("rq_left", 32'(rq_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
